// File: rtl/mano_timing_decode.sv
// Mano basic computer timing and decode stage.
// Runs the sequence counter, emits one-hot T timing and one-hot D opcode decode.
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - synchronous active-low reset
//   start   - leave HALTED and begin at T0
//   halt    - stop sequencing (HLT)
//   sc_clr  - end of instruction, SC returns to 0
//   instr   - instruction word, opcode/indirect latched during T1
//   T       - one-hot timing, T[k] = (sc == k) & run
//   D       - one-hot decode of the latched opcode
//   I       - latched indirect bit
//   sc      - raw sequence counter
//   run     - sequencing active (S flip-flop)
module mano_timing_decode #(
    parameter int SC_W    = 3,
    parameter int OPC_LSB = 12,
    parameter int I_BIT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 sc_clr,
    input  logic [15:0]          instr,
    output logic [2**SC_W-1:0]   T,
    output logic [7:0]           D,
    output logic                 I,
    output logic [SC_W-1:0]      sc,
    output logic                 run
);

    typedef enum logic {
        HALTED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [2:0]      opc_q, opc_d;
    logic            i_q, i_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HALTED;
            sc_q    <= '0;
            opc_q   <= '0;
            i_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            opc_q   <= opc_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        opc_d   = opc_q;
        i_d     = i_q;
        unique case (state_q)
            HALTED: begin
                sc_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                    sc_d    = '0;
                end else begin
                    // Fetch latch at T1; a concurrent sc_clr must not block it
                    if (sc_q == SC_W'(1)) begin
                        opc_d = instr[OPC_LSB+2:OPC_LSB];
                        i_d   = instr[I_BIT];
                    end
                    if (sc_clr) begin
                        sc_d = '0;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = HALTED;
                sc_d    = '0;
            end
        endcase
    end

    always_comb begin
        T = '0;
        if (state_q == RUN) begin
            T[sc_q] = 1'b1;
        end
    end

    always_comb begin
        D        = '0;
        D[opc_q] = 1'b1;
    end

    assign I   = i_q;
    assign sc  = sc_q;
    assign run = (state_q == RUN);

endmodule

// File: tb/tb_mano_timing_decode.sv
// Self-checking bench for mano_timing_decode.
// Directed scenarios against fixed values, random traffic against a reference model.
module tb_mano_timing_decode;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        sc_clr;
    logic [15:0] instr;
    logic [7:0]  T;
    logic [7:0]  D;
    logic        I;
    logic [2:0]  sc;
    logic        run;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers
    int m_sc  = 0;
    int m_opc = 0;
    int m_i   = 0;
    int m_run = 0;

    mano_timing_decode dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .halt   (halt),
        .sc_clr (sc_clr),
        .instr  (instr),
        .T      (T),
        .D      (D),
        .I      (I),
        .sc     (sc),
        .run    (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: advance the model with the inputs seen at the edge,
    // then sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_sc = 0; m_opc = 0; m_i = 0; m_run = 0;
        end else if (m_run == 0) begin
            m_sc = 0;
            if (start) m_run = 1;
        end else if (halt) begin
            m_run = 0; m_sc = 0;
        end else begin
            if (m_sc == 1) begin
                m_opc = (int'(instr) / 4096) % 8;
                m_i   = int'(instr) / 32768;
            end
            m_sc = sc_clr ? 0 : (m_sc + 1) % 8;
        end
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; halt = 0; sc_clr = 0; instr = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({T, D, I, sc, run} !== {8'h00, 8'h01, 1'b0, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got T=%h D=%h I=%b sc=%0d run=%b, exp T=00 D=01 I=0 sc=0 run=0",
                         T, D, I, sc, run);
            end
        end
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({T, D, I, sc, run} !== {8'h00, 8'h01, 1'b0, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle: got T=%h D=%h I=%b sc=%0d run=%b, exp T=00 D=01 I=0 sc=0 run=0",
                         T, D, I, sc, run);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] et;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 10; k++) begin
            et = 8'(1 << (k % 8));
            checks++;
            if (T !== et || sc !== 3'(k % 8) || run !== 1'b1) begin
                errors++;
                $display("FAIL wrap_%0d: got T=%h sc=%0d run=%b, exp T=%h sc=%0d run=1",
                         k, T, sc, run, et, k % 8);
            end
            tick();
        end
    endtask

    task automatic test_fetch();
        rst_n = 0; idle_inputs(); tick(); rst_n = 1;
        start = 1; tick(); start = 0;   // T0
        tick();                          // T1
        instr = 16'hC123;
        tick();                          // T2
        checks++;
        if (T !== 8'h04 || D !== 8'h10 || I !== 1'b1) begin
            errors++;
            $display("FAIL fetch_c123: got T=%h D=%h I=%b, exp T=04 D=10 I=1", T, D, I);
        end
        instr = 16'h0000;
        tick(); tick();                  // T4
        sc_clr = 1;
        tick();
        sc_clr = 0;
        checks++;
        if (T !== 8'h01 || D !== 8'h10 || sc !== 3'd0) begin
            errors++;
            $display("FAIL fetch_scclr: got T=%h D=%h sc=%0d, exp T=01 D=10 sc=0", T, D, sc);
        end
        tick();                          // T1
        instr = 16'h7800;
        tick();                          // T2
        checks++;
        if (T !== 8'h04 || D !== 8'h80 || I !== 1'b0) begin
            errors++;
            $display("FAIL fetch_7800: got T=%h D=%h I=%b, exp T=04 D=80 I=0", T, D, I);
        end
    endtask

    task automatic test_simultaneous();
        // Currently at T2 from previous test
        sc_clr = 1; tick(); sc_clr = 0; // T0
        tick();                          // T1
        sc_clr = 1; instr = 16'h2000;
        tick();
        sc_clr = 0;
        checks++;
        if (T !== 8'h01 || D !== 8'h04) begin
            errors++;
            $display("FAIL simul_t1_clr: got T=%h D=%h, exp T=01 D=04", T, D);
        end
        tick(); tick(); tick();          // T3
        checks++;
        if (T !== 8'h08) begin
            errors++;
            $display("FAIL simul_reach_t3: got T=%h, exp 08", T);
        end
        halt = 1; start = 1;
        tick();
        halt = 0; start = 0;
        checks++;
        if (run !== 1'b0 || T !== 8'h00 || sc !== 3'd0 || D !== 8'h04) begin
            errors++;
            $display("FAIL simul_halt_start: got run=%b T=%h sc=%0d D=%h, exp run=0 T=00 sc=0 D=04",
                     run, T, sc, D);
        end
    endtask

    task automatic test_reset_mid();
        start = 1; tick(); start = 0;   // T0
        tick();                          // T1
        instr = 16'h7800;
        tick(); tick(); tick(); tick();  // T5
        checks++;
        if (T !== 8'h20 || D !== 8'h80) begin
            errors++;
            $display("FAIL mid_pre: got T=%h D=%h, exp T=20 D=80", T, D);
        end
        rst_n = 0; start = 1; sc_clr = 1;
        tick();
        rst_n = 1; start = 0; sc_clr = 0;
        checks++;
        if ({T, D, I, run} !== {8'h00, 8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got T=%h D=%h I=%b run=%b, exp T=00 D=01 I=0 run=0",
                     T, D, I, run);
        end
        start = 1; tick(); start = 0;
        checks++;
        if (T !== 8'h01 || run !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: got T=%h run=%b, exp T=01 run=1", T, run);
        end
    endtask

    task automatic test_halted_restart();
        halt = 1; tick(); halt = 0;
        sc_clr = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (T !== 8'h00 || sc !== 3'd0 || run !== 1'b0) begin
                errors++;
                $display("FAIL halted_scclr_%0d: got T=%h sc=%0d run=%b, exp T=00 sc=0 run=0",
                         k, T, sc, run);
            end
        end
        sc_clr = 0;
        start = 1; tick(); start = 0;
        checks++;
        if (T !== 8'h01) begin
            errors++;
            $display("FAIL restart_t0: got T=%h, exp 01", T);
        end
        tick();
        checks++;
        if (T !== 8'h02) begin
            errors++;
            $display("FAIL restart_t1: got T=%h, exp 02", T);
        end
    endtask

    task automatic test_random();
        logic [7:0] et, ed;
        rst_n = 0; idle_inputs(); tick(); rst_n = 1;
        for (int k = 0; k < 400; k++) begin
            rst_n  = ($urandom_range(63) != 0);
            start  = ($urandom_range(7) == 0);
            halt   = ($urandom_range(19) == 0);
            sc_clr = ($urandom_range(5) == 0);
            instr  = 16'($urandom);
            tick();
            et = (m_run != 0) ? 8'(1 << m_sc) : 8'h00;
            ed = 8'(1 << m_opc);
            checks++;
            if ({T, D, I, sc, run} !== {et, ed, 1'(m_i), 3'(m_sc), 1'(m_run)}) begin
                errors++;
                $display("FAIL random_%0d: got T=%h D=%h I=%b sc=%0d run=%b, exp T=%h D=%h I=%0d sc=%0d run=%0d",
                         k, T, D, I, sc, run, et, ed, m_i, m_sc, m_run);
            end
        end
        rst_n = 1; idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_wrap();
        test_fetch();
        test_simultaneous();
        test_reset_mid();
        test_halted_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mano_timing_decode.md
Name: mano_timing_decode

Overview:
- Upstream timing and decode stage of the Mano basic computer control unit.
- Runs the sequence counter (SC) and decodes it into one-hot timing signals T[7:0].
- Latches the fetched instruction's opcode and indirect bit, and decodes the opcode into one-hot D[7:0].
- The T/D pair drives the PC, AR, IR and ALU control-equation blocks (e.g. PC load = D4&T4, PC inc = T1); those blocks return sc_clr at end of instruction.

Parameters:
- SC_W, 3, sequence counter width; T width is 2**SC_W (8 at default).
- OPC_LSB, 12, bit position of the opcode LSB in instr; opcode is instr[OPC_LSB+2:OPC_LSB].
- I_BIT, 15, bit position of the indirect-address bit in instr.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; one clock, synchronous reset.
- start  input  1  pulse: leave halt state and begin at T0.
- halt  input  1  pulse: stop sequencing (HLT instruction decode).
- sc_clr  input  1  end-of-instruction: SC returns to 0 on next edge.
- instr  input  16  instruction word from memory bus; sampled during T1.
- T  output  8  one-hot timing signals, T[k] = (SC==k) & run.
- D  output  8  one-hot opcode decode of latched opcode.
- I  output  1  latched indirect bit.
- sc  output  3  raw sequence counter value.
- run  output  1  sequencing active (Mano S flip-flop).

Behaviour:
- State: sc[SC_W-1:0], opc[2:0], i_q, run. T, D and I are combinational from state (zero latency from register outputs).
- Reset (rst_n=0 at edge): sc=0, opc=0, i_q=0, run=0.
  - Resulting outputs: T=8'h00, D=8'h01, I=0, sc=0, run=0.
  - Reset has priority over all other inputs, including mid-instruction.
- Two states: HALTED (run=0) and RUN (run=1).
- HALTED:
  - T=0; sc held at 0; opc and i_q held.
  - start=1 -> RUN with sc=0, so T0 is asserted in the cycle after the start edge.
  - sc_clr is ignored in HALTED.
- RUN, per edge, priority highest first:
  1. halt=1 -> run=0, sc=0 (HALTED). halt wins over a simultaneous start or sc_clr.
  2. sc_clr=1 -> sc=0.
  3. Otherwise sc=sc+1 mod 2**SC_W; 7 wraps to 0 with no flag.
- start in RUN is ignored (no restart).
- Opcode latch: on an edge where run=1 and sc==1 (T1 active) and halt=0:
  - opc <= instr[OPC_LSB+2:OPC_LSB]; i_q <= instr[I_BIT].
  - sc_clr in the same cycle does not suppress the latch.
- D[k] = (opc==k), always exactly one-hot, including in HALTED. New D is valid from T2 onward.
- D and I are stable from T2 until the next T1 edge.
- T is one-hot while run=1 and all-zero while run=0. It is never multi-hot.
- halt and sc_clr pulses longer than one cycle are acted on each cycle: sc stays 0, and T0 repeats under sc_clr.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release with start=0 for 5 cycles -> T=00, D=01, I=0, sc=0, run=0 throughout.
- Free-run and wrap: start pulse, then no sc_clr for 10 cycles -> T sequence 01,02,04,08,10,20,40,80,01,02; sc=0..7,0,1.
- Fetch/decode: start; instr=16'hC123 held at T1 -> from T2: D=8'h10 (opc 4), I=1. Then sc_clr at T4 -> next cycle T=01 and D still 8'h10. Next T1 with instr=16'h7800 -> D=8'h80, I=0.
- Simultaneous events: in T1, assert sc_clr with instr=16'h2000 -> next cycle T=01, D=8'h04. In T3, assert halt and start together -> run=0, T=00, sc=0, D held at 8'h04.
- Reset mid-instruction: at T5 with D=8'h80, rst_n=0 for one edge -> T=00, D=01, I=0, run=0. A subsequent start gives T0 on the following cycle.
- Halted restart: after halt, pulse sc_clr for 3 cycles -> no change. Then start -> T=01 next cycle, followed by 02.
